luma_binarizer_adaptive: RTL
============================

// Module: luma_binarizer_adaptive
// PURPOSE
//  Upstream of the EAN-13 scanner: turns an 8-bit luma pixel stream into the 1-bit bar/space stream it consumes.
//  Local-mean adaptive threshold over a horizontal window centred on each pixel; fixed threshold where the window is not fully inside the active line.
//  Sync/active are delayed with the data so the scanner sees an aligned stream. Output 1 = dark (bar), 0 = light (space).
// PARAMETERS
//  WIN_LOG2       4    window W = 2^WIN_LOG2 pixels; legal 2..6; W must be >= 2*MAX_MODULE_WIDTH of the scanner
//  OFFSET         8    dark if luma + OFFSET < window mean (8-bit unsigned)
//  FIX_THRESHOLD  128  dark if luma < FIX_THRESHOLD when the window is not full
// PORTS
//  iClk          in   1  clock, all logic on rising edge
//  iRst          in   1  synchronous reset, active-low (0 = reset)
//  iPixelSync    in   1  frame sync pulse, passed through
//  iPixelActive  in   1  pixel valid / active video
//  iPixelLuma    in   8  pixel luminance, 0 = black
//  oPixelSync    out  1  iPixelSync delayed LAT cycles
//  oPixelActive  out  1  iPixelActive delayed LAT cycles
//  oPixelData    out  1  binarized pixel, qualified by oPixelActive
// BEHAVIOUR
//  - LAT = W/2 + 2 cycles (W/2 + 3 with despeckle); data, sync and active are shifted every clock.
//  - Stage 0: register inputs. Stage 1: W-deep shift registers for luma and active flag.
//  - Running sum S (8+WIN_LOG2 bits): S += new active ? luma : 0; S -= dropped active ? luma : 0.
//  - Running count C (WIN_LOG2+1 bits): same update rule using active flags; no divider used.
//  - Window for output pixel p = input pixels p-W/2 .. p+W/2-1; centre tap = index W/2 of the window.
//  - Mean M = S >> WIN_LOG2 (floor).
//  - Compare stage, registered:
//      C == W -> dark = (centre + OFFSET) < M, 9-bit add, no wrap
//      C <  W -> dark = centre < FIX_THRESHOLD (line edges, first/last W/2 pixels)
//  - oPixelData forced 0 when the delayed active flag is 0.
//  - Blanking samples never enter S or C, so no state carries between lines or frames.
//  - Sync and active travel in the same shift chain as luma; relative timing is preserved exactly.
//  - Reset (iRst=0 at edge): all shift registers, S, C and outputs go to 0.
//      Outputs stay 0 during reset and for LAT cycles after release, even mid-line.
//      The first line after reset uses the fixed threshold until C reaches W.
//  - Continuous active (no blanking) is legal: C saturates at W and S stays exact.
// CONFIGURATION
//  BINARIZER_DESPECKLE_EN defined:
//    - one extra register stage; output = majority(prev, cur, next) of the binarized pixels.
//    - A neighbour outside active is replaced by cur.
//    - Removes isolated 1-pixel bars and spaces; LAT = W/2 + 3.
//  Not defined: no filter, LAT = W/2 + 2, single-pixel runs pass through.
// TESTING  (W=16, OFFSET=8, FIX_THRESHOLD=128; LAT=10, or 11 with despeckle)
//  1. Reset: iRst=0 for 3 clk with active luma 0 -> all outputs 0.
//     Release -> outputs stay 0 for 10 clk, then oPixelActive follows input.
//  2. Sync: 1-clk iPixelSync, then a 32-px line of luma 200 -> oPixelSync pulse exactly 10 clk later.
//     oPixelActive high 32 clk; oPixelData all 0.
//  3. Bar: line 12 px @200, 8 px @40, 12 px @200 -> oPixelData = 12x0, 8x1, 12x0.
//     Edge pixels use FIX_THRESHOLD: 40 -> 1, 200 -> 0.
//  4. Offset boundary: full window of 14 px @107, 1 px @10, centre @92 (S=1600, M=100) -> centre 0.
//     Same window with 10 -> 11 and centre @91 (M=100) -> centre 1.
//  5. Fixed boundary: 4-px line luma 127,128,127,128 -> 1,0,1,0.
//  6. Speckle: 32 px @200 with one px @20 at index 16.
//     With BINARIZER_DESPECKLE_EN -> all 0 at LAT 11; without -> single 1 at index 16, LAT 10.
//  7. Mid-line reset: iRst=0 for 1 clk at px 10 of a 32-px line -> outputs 0 from the next clk.
//     Resumes 10 clk after release with the fixed threshold until 16 active px are seen.

Source files
------------

// File: rtl/luma_binarizer_adaptive.sv
// Local-mean adaptive luma binarizer: 8-bit pixel stream in, 1-bit bar/space stream out (1 = dark).
// Optional majority-of-three despeckle filter enabled by defining BINARIZER_DESPECKLE_EN.
module luma_binarizer_adaptive #(
    parameter int WIN_LOG2      = 4,
    parameter int OFFSET        = 8,
    parameter int FIX_THRESHOLD = 128
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iPixelSync,
    input  logic       iPixelActive,
    input  logic [7:0] iPixelLuma,
    output logic       oPixelSync,
    output logic       oPixelActive,
    output logic       oPixelData
);
    localparam int WIN   = 1 << WIN_LOG2;
    localparam int HALF  = WIN / 2;
    localparam int SUM_W = 8 + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;

    logic             r_inSync;
    logic             r_inActive;
    logic [7:0]       r_inLuma;
    logic [7:0]       r_lumaSh [WIN];
    logic [WIN-1:0]   r_actSh;
    logic [HALF-1:0]  r_syncSh;
    logic [SUM_W-1:0] r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_cmpSync;
    logic             r_cmpActive;
    logic             r_cmpDark;

    logic [SUM_W-1:0] w_addLuma;
    logic [SUM_W-1:0] w_dropLuma;
    logic [SUM_W-1:0] w_sumNext;
    logic [CNT_W-1:0] w_countNext;
    logic [SUM_W-1:0] w_mean;
    logic [SUM_W-1:0] w_centreOffset;
    logic [7:0]       w_centre;
    logic             w_centreActive;
    logic             w_full;
    logic             w_dark;

    // Only active samples enter or leave the window, so blanking leaves no residue between lines.
    assign w_addLuma   = r_inActive ? SUM_W'(r_inLuma) : '0;
    assign w_dropLuma  = r_actSh[WIN-1] ? SUM_W'(r_lumaSh[WIN-1]) : '0;
    assign w_sumNext   = r_sum + w_addLuma - w_dropLuma;
    assign w_countNext = r_count + CNT_W'(r_inActive) - CNT_W'(r_actSh[WIN-1]);

    // r_lumaSh[0] is the newest sample; the pixel being judged sits HALF-1 places behind it.
    assign w_centre       = r_lumaSh[HALF-1];
    assign w_centreActive = r_actSh[HALF-1];
    assign w_mean         = r_sum >> WIN_LOG2;
    assign w_centreOffset = SUM_W'(w_centre) + SUM_W'(OFFSET);
    assign w_full         = (r_count == CNT_W'(WIN));
    assign w_dark         = w_centreActive &
                            (w_full ? (w_centreOffset < w_mean)
                                    : ({1'b0, w_centre} < 9'(FIX_THRESHOLD)));

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_inSync    <= 1'b0;
            r_inActive  <= 1'b0;
            r_inLuma    <= '0;
            for (int i = 0; i < WIN; i++) begin
                r_lumaSh[i] <= '0;
            end
            r_actSh     <= '0;
            r_syncSh    <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_cmpSync   <= 1'b0;
            r_cmpActive <= 1'b0;
            r_cmpDark   <= 1'b0;
        end else begin
            r_inSync    <= iPixelSync;
            r_inActive  <= iPixelActive;
            r_inLuma    <= iPixelLuma;
            r_lumaSh[0] <= r_inLuma;
            for (int i = 1; i < WIN; i++) begin
                r_lumaSh[i] <= r_lumaSh[i-1];
            end
            r_actSh     <= {r_actSh[WIN-2:0], r_inActive};
            r_syncSh    <= {r_syncSh[HALF-2:0], r_inSync};
            r_sum       <= w_sumNext;
            r_count     <= w_countNext;
            r_cmpSync   <= r_syncSh[HALF-1];
            r_cmpActive <= w_centreActive;
            r_cmpDark   <= w_dark;
        end
    end

`ifdef BINARIZER_DESPECKLE_EN
    logic r_prevDark;
    logic r_prevActive;
    logic r_outSync;
    logic r_outActive;
    logic r_outData;
    logic w_prevVal;
    logic w_nextVal;
    logic w_majority;

    // The next pixel is the unregistered compare result; inactive neighbours borrow the centre value.
    assign w_prevVal  = r_prevActive ? r_prevDark : r_cmpDark;
    assign w_nextVal  = w_centreActive ? w_dark : r_cmpDark;
    assign w_majority = (w_prevVal & r_cmpDark) | (w_prevVal & w_nextVal) | (r_cmpDark & w_nextVal);

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_prevDark   <= 1'b0;
            r_prevActive <= 1'b0;
            r_outSync    <= 1'b0;
            r_outActive  <= 1'b0;
            r_outData    <= 1'b0;
        end else begin
            r_prevDark   <= r_cmpDark;
            r_prevActive <= r_cmpActive;
            r_outSync    <= r_cmpSync;
            r_outActive  <= r_cmpActive;
            r_outData    <= r_cmpActive & w_majority;
        end
    end

    assign oPixelSync   = r_outSync;
    assign oPixelActive = r_outActive;
    assign oPixelData   = r_outData;
`else
    assign oPixelSync   = r_cmpSync;
    assign oPixelActive = r_cmpActive;
    assign oPixelData   = r_cmpDark;
`endif

endmodule
